// File: rtl/executer_m.sv
// executer_m: execute stage with N-way operand forwarding, a single-cycle ALU/branch path and an iterative RV32M unit.
// ALU ops: 0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and,10 eq,11 ne,12 ge,13 geu,14 pass-b; 15 is unknown.
module executer_m #(
    parameter int unsigned FWD_SRCS     = 2,
    parameter int unsigned M_RADIX_BITS = 1,
    localparam int unsigned SW          = $clog2(FWD_SRCS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [3:0]              alu_op,
    input  logic                    m_en,
    input  logic [2:0]              m_op,
    input  logic [31:0]             alu_a,
    input  logic [31:0]             alu_b,
    input  logic [32*FWD_SRCS-1:0]  fwd_data,
    input  logic [SW-1:0]           alu_a_src,
    input  logic [SW-1:0]           alu_b_src,
    input  logic [31:0]             pc,
    input  logic [31:0]             imm_value,
    input  logic                    branch_en,
    input  logic                    jal_en,
    input  logic                    jalr_en,
    input  logic                    mem_to_reg_in,
    input  logic [1:0]              bytes_in,
    input  logic [31:0]             wdata_in,
    input  logic                    we_in,
    input  logic                    re_in,
    input  logic [4:0]              rd_in,
    input  logic                    reg_we_in,
    output logic                    mem_to_reg_out,
    output logic [1:0]              bytes_out,
    output logic [31:0]             wdata_out,
    output logic                    we_out,
    output logic                    re_out,
    output logic [4:0]              rd_out,
    output logic                    reg_we_out,
    output logic [31:0]             alu_result,
    output logic                    alu_unknown_op,
    output logic [31:0]             addr_out,
    output logic                    addr_out_en,
    output logic                    run_out,
    output logic                    busy
);

    localparam logic [5:0] N_STEPS = 6'(32 / M_RADIX_BITS);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_EQ, OP_NE, OP_GE, OP_GEU, OP_PASSB
    } alu_op_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  mop_q, mop_d;
    logic        sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d, bzero_q, bzero_d;
    logic [31:0] dvd_q, dvd_d, work_q, work_d;
    logic [63:0] acc_q, acc_d, mc_q, mc_d;
    logic [42:0] msb_q, msb_d, sbo_q, sbo_d;
    logic [31:0] res_q, res_d, addr_q, addr_d;
    logic        aen_q, aen_d, run_q, run_d, busy_q, busy_d;

    logic [31:0] op_a, op_b, alu_y, ex_y, addr_tgt, mag_a, mag_b;
    logic        alu_bad, addr_take, is_signed_a, is_signed_b, neg_a, neg_b;
    logic [31:0] step_work, quo, rmd, m_res;
    logic [63:0] step_acc, step_mc, prod;
    logic [32:0] rem;
    logic [42:0] sb_in;

    assign sb_in = {mem_to_reg_in, bytes_in, wdata_in, we_in, re_in, rd_in, reg_we_in};

    always_comb begin
        op_a = alu_a;
        op_b = alu_b;
        for (int unsigned k = 0; k < FWD_SRCS; k++) begin
            if (alu_a_src == SW'(k + 1)) op_a = fwd_data[k*32 +: 32];
            if (alu_b_src == SW'(k + 1)) op_b = fwd_data[k*32 +: 32];
        end
    end

    always_comb begin
        alu_y   = '0;
        alu_bad = 1'b0;
        case (alu_op)
            OP_ADD:   alu_y = op_a + op_b;
            OP_SUB:   alu_y = op_a - op_b;
            OP_SLL:   alu_y = op_a << op_b[4:0];
            OP_SLT:   alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
            OP_SLTU:  alu_y = {31'b0, op_a < op_b};
            OP_XOR:   alu_y = op_a ^ op_b;
            OP_SRL:   alu_y = op_a >> op_b[4:0];
            OP_SRA:   alu_y = 32'($signed(op_a) >>> op_b[4:0]);
            OP_OR:    alu_y = op_a | op_b;
            OP_AND:   alu_y = op_a & op_b;
            OP_EQ:    alu_y = {31'b0, op_a == op_b};
            OP_NE:    alu_y = {31'b0, op_a != op_b};
            OP_GE:    alu_y = {31'b0, $signed(op_a) >= $signed(op_b)};
            OP_GEU:   alu_y = {31'b0, op_a >= op_b};
            OP_PASSB: alu_y = op_b;
            default:  alu_bad = 1'b1;
        endcase
    end

    // Jumps write the link address; branches are taken when the compare op yields 1.
    assign ex_y           = (jal_en | jalr_en) ? pc + 32'd4 : alu_y;
    assign addr_tgt       = jalr_en ? ((op_a + imm_value) & ~32'd1) : (pc + imm_value);
    assign addr_take      = jal_en | jalr_en | (branch_en & alu_y[0]);
    assign alu_unknown_op = alu_bad & ~m_en;

    assign is_signed_a = (m_op == 3'd0) || (m_op == 3'd1) || (m_op == 3'd2) || (m_op == 3'd4) || (m_op == 3'd6);
    assign is_signed_b = (m_op == 3'd0) || (m_op == 3'd1) || (m_op == 3'd4) || (m_op == 3'd6);
    assign neg_a       = is_signed_a & op_a[31];
    assign neg_b       = is_signed_b & op_b[31];
    assign mag_a       = neg_a ? -op_a : op_a;
    assign mag_b       = neg_b ? -op_b : op_b;

    // One radix step: work holds the multiplier (shifted right) or the dividend/quotient (shifted left).
    always_comb begin
        step_work = work_q;
        step_acc  = acc_q;
        step_mc   = mc_q;
        rem       = '0;
        for (int unsigned i = 0; i < M_RADIX_BITS; i++) begin
            if (!mop_q[2]) begin
                if (step_work[0]) step_acc = step_acc + step_mc;
                step_work = step_work >> 1;
                step_mc   = step_mc << 1;
            end else begin
                rem       = {step_acc[31:0], step_work[31]};
                step_work = step_work << 1;
                if (rem >= {1'b0, step_mc[31:0]}) begin
                    rem          = rem - {1'b0, step_mc[31:0]};
                    step_work[0] = 1'b1;
                end
                step_acc = {32'b0, rem[31:0]};
            end
        end
    end

    always_comb begin
        prod = (sgn_a_q ^ sgn_b_q) ? -acc_q : acc_q;
        quo  = (sgn_a_q ^ sgn_b_q) ? -work_q : work_q;
        rmd  = sgn_a_q ? -acc_q[31:0] : acc_q[31:0];
        if (bzero_q) begin
            quo = '1;
            rmd = dvd_q;
        end
        if (!mop_q[2]) m_res = (mop_q[1:0] == 2'd0) ? prod[31:0] : prod[63:32];
        else           m_res = mop_q[1] ? rmd : quo;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mop_d   = mop_q;
        sgn_a_d = sgn_a_q;
        sgn_b_d = sgn_b_q;
        bzero_d = bzero_q;
        dvd_d   = dvd_q;
        work_d  = work_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        msb_d   = msb_q;
        res_d   = res_q;
        addr_d  = addr_q;
        aen_d   = aen_q;
        sbo_d   = sbo_q;
        busy_d  = busy_q;
        run_d   = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run && !stall) begin
                        if (m_en) begin
                            mop_d   = m_op;
                            sgn_a_d = neg_a;
                            sgn_b_d = neg_b;
                            bzero_d = (op_b == 32'd0);
                            dvd_d   = op_a;
                            work_d  = m_op[2] ? mag_a : mag_b;
                            mc_d    = {32'b0, m_op[2] ? mag_b : mag_a};
                            acc_d   = '0;
                            msb_d   = sb_in;
                            cnt_d   = N_STEPS;
                            busy_d  = 1'b1;
                            state_d = S_CALC;
                        end else begin
                            res_d  = ex_y;
                            addr_d = addr_tgt;
                            aen_d  = addr_take;
                            sbo_d  = sb_in;
                            run_d  = 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    work_d = step_work;
                    acc_d  = step_acc;
                    mc_d   = step_mc;
                    cnt_d  = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) state_d = S_DONE;
                end
                S_DONE: begin
                    if (!stall) begin
                        res_d   = m_res;
                        aen_d   = 1'b0;
                        sbo_d   = msb_q;
                        run_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mop_q   <= '0;
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
            bzero_q <= 1'b0;
            dvd_q   <= '0;
            work_q  <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            msb_q   <= '0;
            res_q   <= '0;
            addr_q  <= '0;
            aen_q   <= 1'b0;
            sbo_q   <= '0;
            busy_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mop_q   <= mop_d;
            sgn_a_q <= sgn_a_d;
            sgn_b_q <= sgn_b_d;
            bzero_q <= bzero_d;
            dvd_q   <= dvd_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            msb_q   <= msb_d;
            res_q   <= res_d;
            addr_q  <= addr_d;
            aen_q   <= aen_d;
            sbo_q   <= sbo_d;
            busy_q  <= busy_d;
            run_q   <= run_d;
        end
    end

    assign {mem_to_reg_out, bytes_out, wdata_out, we_out, re_out, rd_out, reg_we_out} = sbo_q;
    assign alu_result  = res_q;
    assign addr_out    = addr_q;
    assign addr_out_en = aen_q;
    assign run_out     = run_q;
    assign busy        = busy_q;

endmodule
